umi_regif_arb: RTL



---
 rtl/umi_regif_arb.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/umi_regif_arb.sv
// Round-robin arbiter sharing one UMI register-interface target among N requesters.
// One transaction is outstanding at the target at a time; the grant is held until response or timeout.
module umi_regif_arb #(
  parameter int N       = 4,
  parameter int AW      = 64,
  parameter int CW      = 32,
  parameter int DW      = 256,
  parameter int TIMEOUT = 255,
  localparam int IW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            nreset,
  // requester side
  input  logic [N-1:0]    in_req_valid,
  input  logic [N*CW-1:0] in_req_cmd,
  input  logic [N*AW-1:0] in_req_dstaddr,
  input  logic [N*AW-1:0] in_req_srcaddr,
  input  logic [N*DW-1:0] in_req_data,
  output logic [N-1:0]    in_req_ready,
  output logic [N-1:0]    in_resp_valid,
  output logic [CW-1:0]   in_resp_cmd,
  output logic [AW-1:0]   in_resp_dstaddr,
  output logic [AW-1:0]   in_resp_srcaddr,
  output logic [DW-1:0]   in_resp_data,
  input  logic [N-1:0]    in_resp_ready,
  // shared target side
  output logic            out_req_valid,
  output logic [CW-1:0]   out_req_cmd,
  output logic [AW-1:0]   out_req_dstaddr,
  output logic [AW-1:0]   out_req_srcaddr,
  output logic [DW-1:0]   out_req_data,
  input  logic            out_req_ready,
  input  logic            out_resp_valid,
  input  logic [CW-1:0]   out_resp_cmd,
  input  logic [AW-1:0]   out_resp_dstaddr,
  input  logic [AW-1:0]   out_resp_srcaddr,
  input  logic [DW-1:0]   out_resp_data,
  output logic            out_resp_ready,
  // error reporting
  input  logic            err_clear,
  output logic            err_timeout,
  output logic            err_stray,
  output logic [IW-1:0]   err_id
);

  localparam int CTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CTW-1:0]  cnt_q, cnt_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_stray_q, err_stray_d;
  logic [IW-1:0]   err_id_q, err_id_d;

  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic [4:0]      req_op;
  logic            req_nonposted;
  logic            req_hs;
  logic            resp_hs;
  logic            timeout_evt;
  logic            stray_evt;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    if (int'(v) == N - 1) r = '0;
    else                  r = v + 1'b1;
    return r;
  endfunction

  // First valid requester at or after ptr, scanning upward modulo N
  always_comb begin
    scan_idx   = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % N);
      if (!pick_found && in_req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign out_req_cmd     = in_req_cmd[int'(owner_q)*CW +: CW];
  assign out_req_dstaddr = in_req_dstaddr[int'(owner_q)*AW +: AW];
  assign out_req_srcaddr = in_req_srcaddr[int'(owner_q)*AW +: AW];
  assign out_req_data    = in_req_data[int'(owner_q)*DW +: DW];

  assign in_resp_cmd     = out_resp_cmd;
  assign in_resp_dstaddr = out_resp_dstaddr;
  assign in_resp_srcaddr = out_resp_srcaddr;
  assign in_resp_data    = out_resp_data;

  // Only the current owner sees handshakes; outside WAIT responses are sunk
  always_comb begin
    in_req_ready   = '0;
    in_resp_valid  = '0;
    out_req_valid  = 1'b0;
    out_resp_ready = 1'b1;
    case (state_q)
      ST_REQ: begin
        out_req_valid         = in_req_valid[owner_q];
        in_req_ready[owner_q] = out_req_ready;
      end
      ST_WAIT: begin
        in_resp_valid[owner_q] = out_resp_valid;
        out_resp_ready         = in_resp_ready[owner_q];
      end
      default: ;
    endcase
  end

  assign req_op        = out_req_cmd[4:0];
  assign req_nonposted = (req_op == 5'h01) || (req_op == 5'h03) || (req_op == 5'h09);
  assign req_hs        = out_req_valid & out_req_ready;
  assign resp_hs       = (state_q == ST_WAIT) & out_resp_valid & out_resp_ready;
  assign stray_evt     = (state_q != ST_WAIT) & out_resp_valid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    timeout_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          ptr_d   = wrap_inc(pick_idx);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_hs) begin
          if (req_nonposted) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        // A response accepted on the timeout cycle is a normal completion
        if (resp_hs) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_q == CTW'(TIMEOUT)) && !out_resp_valid) begin
            state_d     = ST_IDLE;
            timeout_evt = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky errors: a new event in the clearing cycle takes precedence
  always_comb begin
    err_timeout_d = err_timeout_q;
    err_stray_d   = err_stray_q;
    err_id_d      = err_id_q;
    if (err_clear) begin
      err_timeout_d = 1'b0;
      err_stray_d   = 1'b0;
    end
    if (timeout_evt) begin
      err_timeout_d = 1'b1;
      err_id_d      = owner_q;
    end
    if (stray_evt) begin
      err_stray_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
      err_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_stray_q   <= err_stray_d;
      err_id_q      <= err_id_d;
    end
  end

  assign err_timeout = err_timeout_q;
  assign err_stray   = err_stray_q;
  assign err_id      = err_id_q;

endmodule
